score_counter_bcd: RTL and testbench

//   Parametrised per-player score keeper for the tug-of-war game.
//   - Counts round wins in multi-digit BCD; each win pulse adds exactly one point (edge-detected).
//   - Freezes at a configurable winning score and flags game over.
//   - Drives one active-low 7-segment pattern per digit to the HEX displays.
//   - One instance per player, fed by the playfield's round-win output.

---
 rtl/score_counter_bcd.sv | 143 ++++++++++++++
 tb/tb_score_counter_bcd.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/score_counter_bcd.sv
// Per-player BCD score keeper: edge-detected win counting, saturation at WIN_SCORE, 7-segment drive.
// Optional leading-zero blanking of the HEX displays when SCORE_BLANK_EN is defined.
//
// state | meaning
// ------+-------------------------------------------------
// PLAY  | game running, rising win edges add one point
// DONE  | score reached WIN_SCORE, increments ignored
module score_counter_bcd #(
   parameter int DIGITS    = 2,
   parameter int WIN_SCORE = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  win,
   input  logic                  clear,
   output logic                  game_over,
   output logic [4*DIGITS-1:0]   score_bcd,
   output logic [7*DIGITS-1:0]   hex
);

   localparam int MAX_SCORE = (10 ** DIGITS) - 1;

   generate
      if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
         $error("score_counter_bcd: DIGITS=%0d outside 1..4", DIGITS);
      end
      if (WIN_SCORE < 1 || WIN_SCORE > MAX_SCORE) begin : g_bad_win
         $error("score_counter_bcd: WIN_SCORE=%0d outside 1..%0d", WIN_SCORE, MAX_SCORE);
      end
   endgenerate

   function automatic logic [4*DIGITS-1:0] to_bcd(input int value);
      int v;
      v      = value;
      to_bcd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         to_bcd[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   localparam logic [4*DIGITS-1:0] WIN_BCD = to_bcd(WIN_SCORE);

   typedef enum logic {
      PLAY = 1'b0,
      DONE = 1'b1
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [4*DIGITS-1:0]   score;
   logic [4*DIGITS-1:0]   score_next;
   logic [4*DIGITS-1:0]   score_inc;
   logic                  win_q;
   logic                  inc;
   logic                  carry;

   assign inc = win & ~win_q;

   // win_q tracks win even during clear so a win raised under clear is absorbed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= PLAY;
         score <= '0;
         win_q <= 1'b0;
      end else begin
         state <= state_next;
         score <= score_next;
         win_q <= win;
      end
   end

   always_comb begin
      score_inc = score;
      carry     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (score[4*i +: 4] == 4'd9) begin
               score_inc[4*i +: 4] = 4'd0;
            end else begin
               score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      score_next = score;
      if (clear) begin
         state_next = PLAY;
         score_next = '0;
      end else if (inc && state == PLAY) begin
         score_next = score_inc;
         if (score_inc == WIN_BCD) begin
            state_next = DONE;
         end
      end
   end

`ifdef SCORE_BLANK_EN
   logic higher_zero;
`endif

   always_comb begin
      game_over = (state == DONE);
      score_bcd = score;
      hex       = '1;
`ifdef SCORE_BLANK_EN
      higher_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (i > 0 && higher_zero && score[4*i +: 4] == 4'd0) begin
            hex[7*i +: 7] = 7'b1111111;
         end else begin
            hex[7*i +: 7] = seg7(score[4*i +: 4]);
         end
         higher_zero = higher_zero && (score[4*i +: 4] == 4'd0);
      end
`else
      for (int i = 0; i < DIGITS; i++) begin
         hex[7*i +: 7] = seg7(score[4*i +: 4]);
      end
`endif
   end

endmodule

// File: tb/tb_score_counter_bcd.sv
// Scoreboard bench for score_counter_bcd (DIGITS=2, WIN_SCORE=12): stimulus pushes expectations,
// a monitor pops and compares them shortly after each sample event.
module tb_score_counter_bcd;

   logic        clk = 1'b0;
   logic        reset;
   logic        win;
   logic        clear;
   logic        game_over;
   logic [7:0]  score_bcd;
   logic [13:0] hex;

   score_counter_bcd #(.DIGITS(2), .WIN_SCORE(12)) dut (
      .clk       (clk),
      .reset     (reset),
      .win       (win),
      .clear     (clear),
      .game_over (game_over),
      .score_bcd (score_bcd),
      .hex       (hex)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  score;
      logic        go;
      logic [13:0] hx;
      string       name;
   } exp_t;

   exp_t q[$];
   event sample_ev;
   int   checks = 0;
   int   errors = 0;

   int   m_score;
   bit   m_go;
   bit   m_wq;

   logic [6:0] seg [10];
   initial begin
      seg[0] = 7'b1000000; seg[1] = 7'b1111001; seg[2] = 7'b0100100;
      seg[3] = 7'b0110000; seg[4] = 7'b0011001; seg[5] = 7'b0010010;
      seg[6] = 7'b0000010; seg[7] = 7'b1111000; seg[8] = 7'b0000000;
      seg[9] = 7'b0010000;
   end

   function automatic logic [13:0] hex_of(input int s);
      logic [6:0] hi;
      hi = seg[s / 10];
`ifdef SCORE_BLANK_EN
      if (s / 10 == 0) hi = 7'b1111111;
`endif
      return {hi, seg[s % 10]};
   endfunction

   task automatic push(input string nm);
      exp_t e;
      e.score = {4'(m_score / 10), 4'(m_score % 10)};
      e.go    = m_go;
      e.hx    = hex_of(m_score);
      e.name  = nm;
      q.push_back(e);
      -> sample_ev;
   endtask

   task automatic step(input logic w, input logic c, input string nm);
      @(negedge clk);
      win   = w;
      clear = c;
      @(posedge clk);
      #1;
      if (c) begin
         m_score = 0;
         m_go    = 1'b0;
      end else if (w && !m_wq && !m_go) begin
         m_score++;
         if (m_score == 12) m_go = 1'b1;
      end
      m_wq = w;
      push(nm);
   endtask

   task automatic pulse(input string nm);
      step(1'b1, 1'b0, nm);
      step(1'b0, 1'b0, {nm, "_low"});
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         #1;
         while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (score_bcd !== e.score) begin
               errors++;
               $display("FAIL %s score_bcd: got %h expected %h", e.name, score_bcd, e.score);
            end
            checks++;
            if (game_over !== e.go) begin
               errors++;
               $display("FAIL %s game_over: got %b expected %b", e.name, game_over, e.go);
            end
            checks++;
            if (hex !== e.hx) begin
               errors++;
               $display("FAIL %s hex: got %b expected %b", e.name, hex, e.hx);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      win   = 1'b0;
      clear = 1'b0;
      m_score = 0;
      m_go    = 1'b0;
      m_wq    = 1'b0;
      #3;
      push("reset_init");
      @(negedge clk);
      reset = 1'b0;

      repeat (5) pulse("count_to5");

      // async reset between edges at score 05
      @(negedge clk);
      #2;
      reset   = 1'b1;
      m_score = 0;
      m_go    = 1'b0;
      m_wq    = 1'b0;
      push("reset_async");
      @(negedge clk);
      reset = 1'b0;

      repeat (5) step(1'b1, 1'b0, "held_win");
      step(1'b0, 1'b0, "held_low");

      step(1'b0, 1'b1, "clear_plain");
      repeat (10) pulse("carry");
      pulse("to11");
      pulse("to12");
      pulse("saturate13");

      step(1'b1, 1'b1, "clear_win");
      step(1'b1, 1'b0, "clear_win_hold");
      step(1'b0, 1'b0, "clear_win_fall");
      pulse("after_clear");

      repeat (4) pulse("blank_to5");

      #30;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
